// File: rtl/chacha_block_loader.sv
// Packs a byte stream little-endian into 32-bit block-state word writes.
// Latency: 1 cycle from 4th byte accept to wr_en; data_ready drops on abort or after the final word.
module chacha_block_loader #(
    parameter int START_WORD = 0,
    parameter int NUM_WORDS  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] FIRST_WORD = 4'(START_WORD);
    localparam logic [3:0] LAST_WORD  = 4'(START_WORD + NUM_WORDS - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t      state, state_nxt;
    logic [1:0]  byte_cnt;
    logic [3:0]  word_cnt;
    logic [23:0] shift_reg;
    logic        accept;
    logic        word_full;
    logic        last_word;

    assign data_ready = (state == LOAD) && !abort;
    assign busy       = (state == LOAD);
    assign accept     = data_valid && data_ready;
    assign word_full  = accept && (byte_cnt == 2'd3);
    assign last_word  = word_full && (word_cnt == LAST_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && !abort) state_nxt = LOAD;
            LOAD: if (abort || last_word) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The 4th byte bypasses shift_reg and goes straight into the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt  <= 2'd0;
            word_cnt  <= 4'd0;
            shift_reg <= 24'd0;
            wr_en     <= 1'b0;
            wr_addr   <= 4'd0;
            wr_data   <= 32'd0;
            done      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (state == IDLE && start && !abort) begin
                word_cnt <= FIRST_WORD;
                byte_cnt <= 2'd0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (!word_full) begin
                    shift_reg[{byte_cnt, 3'b000} +: 8] <= data_in;
                end else begin
                    wr_en   <= 1'b1;
                    wr_addr <= word_cnt;
                    wr_data <= {data_in, shift_reg};
                    done    <= last_word;
                    if (!last_word) word_cnt <= word_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_chacha_block_loader.sv
// Directed bench for chacha_block_loader: default 16-word instance plus a 12..15 instance.
module tb_chacha_block_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  data_in = 8'd0;
    logic        data_valid = 1'b0;
    logic        ready0, wr_en0, busy0, done0;
    logic        ready1, wr_en1, busy1, done1;
    logic [3:0]  addr0, addr1;
    logic [31:0] wdat0, wdat1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  wa0[$], wa1[$];
    logic [31:0] wd0[$], wd1[$];
    int done_cnt0 = 0, done_cnt1 = 0;
    int done_wr0 = 0, done_wr1 = 0;

    always #5 clk = ~clk;

    chacha_block_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
        .data_in(data_in), .data_valid(data_valid), .data_ready(ready0),
        .wr_en(wr_en0), .wr_addr(addr0), .wr_data(wdat0), .busy(busy0), .done(done0)
    );

    chacha_block_loader #(.START_WORD(12), .NUM_WORDS(4)) dut12 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
        .data_in(data_in), .data_valid(data_valid), .data_ready(ready1),
        .wr_en(wr_en1), .wr_addr(addr1), .wr_data(wdat1), .busy(busy1), .done(done1)
    );

    always @(negedge clk) begin
        if (wr_en0) begin wa0.push_back(addr0); wd0.push_back(wdat0); end
        if (wr_en1) begin wa1.push_back(addr1); wd1.push_back(wdat1); end
        if (done0) begin done_cnt0++; if (wr_en0) done_wr0++; end
        if (done1) begin done_cnt1++; if (wr_en1) done_wr1++; end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
        done_cnt0 = 0; done_cnt1 = 0; done_wr0 = 0; done_wr1 = 0;
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
    endtask

    // Streams n bytes first..first+n-1; returns just after the edge accepting the last one.
    task automatic send(input int first, input int n, input bit gaps, input bit pstart, input bit sel);
        int  i = 0;
        int  guard = 0;
        logic rdy;
        while (i < n && guard < 4000) begin
            @(negedge clk);
            data_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            data_in    = 8'(first + i);
            if (pstart) start0 = guard[0];
            #1 rdy = sel ? ready1 : ready0;
            @(posedge clk);
            if (data_valid && rdy) i++;
            guard++;
        end
        if (i < n) check_eq("send_timeout", 32'(i), 32'(n));
    endtask

    task automatic idle_inputs();
        data_valid = 1'b0; start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic check_full_load(input string tag);
        check_eq({tag, "_nwr"}, 32'(wa0.size()), 32'd16);
        for (int w = 0; w < 16 && w < wa0.size(); w++) begin
            check_eq({tag, "_addr"}, 32'(wa0[w]), 32'(w));
            check_eq({tag, "_data"}, wd0[w],
                     {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        end
        check_eq({tag, "_done_cnt"}, 32'(done_cnt0), 32'd1);
        check_eq({tag, "_done_wr"}, 32'(done_wr0), 32'd1);
    endtask

    initial begin
        // Reset state
        #2;
        check_eq("rst_ready", 32'(ready0), 32'd0);
        check_eq("rst_wr_en", 32'(wr_en0), 32'd0);
        check_eq("rst_busy", 32'(busy0), 32'd0);
        check_eq("rst_done", 32'(done0), 32'd0);
        check_eq("rst_addr", 32'(addr0), 32'd0);
        check_eq("rst_data", wdat0, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // 1: continuous stream, default parameters
        clear_log();
        pulse_start(1'b0);
        check_eq("t1_busy", 32'(busy0), 32'd1);
        check_eq("t1_ready", 32'(ready0), 32'd1);
        send(0, 64, 1'b0, 1'b0, 1'b0);
        @(negedge clk); idle_inputs();
        check_eq("t1_done_pulse", 32'(done0), 32'd1);
        check_eq("t1_wr_en_last", 32'(wr_en0), 32'd1);
        check_eq("t1_last_data", wdat0, 32'h3F3E3D3C);
        check_eq("t1_busy_drop", 32'(busy0), 32'd0);
        check_eq("t1_ready_drop", 32'(ready0), 32'd0);
        @(negedge clk);
        check_eq("t1_done_once", 32'(done0), 32'd0);
        check_eq("t1_hold_addr", 32'(addr0), 32'd15);
        check_full_load("t1");

        // 2: random valid gaps
        clear_log();
        pulse_start(1'b0);
        send(0, 64, 1'b1, 1'b0, 1'b0);
        @(negedge clk); idle_inputs();
        check_eq("t2_done_pulse", 32'(done0), 32'd1);
        @(negedge clk);
        check_full_load("t2");

        // 3: abort after 6 bytes, then restart
        clear_log();
        pulse_start(1'b0);
        send(0, 6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        abort = 1'b1; data_valid = 1'b1; data_in = 8'h06;
        #1 check_eq("t3_ready_abort", 32'(ready0), 32'd0);
        @(negedge clk);
        abort = 1'b0; idle_inputs();
        #1 check_eq("t3_ready_after", 32'(ready0), 32'd0);
        check_eq("t3_busy_after", 32'(busy0), 32'd0);
        @(negedge clk);
        check_eq("t3_nwr", 32'(wa0.size()), 32'd1);
        if (wa0.size() > 0) begin
            check_eq("t3_addr", 32'(wa0[0]), 32'd0);
            check_eq("t3_data", wd0[0], 32'h03020100);
        end
        check_eq("t3_no_done", 32'(done_cnt0), 32'd0);
        clear_log();
        pulse_start(1'b0);
        send(16, 4, 1'b0, 1'b0, 1'b0);
        @(negedge clk); idle_inputs();
        check_eq("t3_restart_wr", 32'(wr_en0), 32'd1);
        check_eq("t3_restart_addr", 32'(addr0), 32'd0);
        check_eq("t3_restart_data", wdat0, 32'h13121110);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // 4: start pulsed throughout a load
        clear_log();
        pulse_start(1'b0);
        send(0, 64, 1'b0, 1'b1, 1'b0);
        @(negedge clk); idle_inputs();
        check_eq("t4_done_pulse", 32'(done0), 32'd1);
        @(negedge clk);
        check_full_load("t4");

        // 5: reset after 10 bytes
        clear_log();
        pulse_start(1'b0);
        send(0, 10, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        idle_inputs();
        check_eq("t5_pre_addr", 32'(addr0), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t5_ready", 32'(ready0), 32'd0);
        check_eq("t5_busy", 32'(busy0), 32'd0);
        check_eq("t5_wr_en", 32'(wr_en0), 32'd0);
        check_eq("t5_addr", 32'(addr0), 32'd0);
        check_eq("t5_data", wdat0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        data_valid = 1'b1; data_in = 8'h55;
        repeat (6) @(negedge clk);
        data_valid = 1'b0;
        check_eq("t5_idle_busy", 32'(busy0), 32'd0);
        check_eq("t5_idle_ready", 32'(ready0), 32'd0);
        check_eq("t5_nwr", 32'(wa0.size()), 32'd2);

        // 6: START_WORD=12, NUM_WORDS=4
        clear_log();
        pulse_start(1'b1);
        check_eq("t6_busy", 32'(busy1), 32'd1);
        send(8'hA0, 16, 1'b0, 1'b0, 1'b1);
        @(negedge clk); idle_inputs();
        check_eq("t6_done_pulse", 32'(done1), 32'd1);
        check_eq("t6_busy_drop", 32'(busy1), 32'd0);
        @(negedge clk);
        check_eq("t6_nwr", 32'(wa1.size()), 32'd4);
        for (int w = 0; w < 4 && w < wa1.size(); w++) begin
            check_eq("t6_addr", 32'(wa1[w]), 32'(12 + w));
            check_eq("t6_data", wd1[w],
                     {8'(8'hA3 + 4*w), 8'(8'hA2 + 4*w), 8'(8'hA1 + 4*w), 8'(8'hA0 + 4*w)});
        end
        check_eq("t6_done_wr", 32'(done_wr1), 32'd1);
        check_eq("t6_dflt_idle", 32'(wa0.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
